// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_hold_buf.sv
// One-entry instruction buffer used while IF/ID is stalled.
module fetch_hold_buf
    import fetch_pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] dout
);

    always_ff @(posedge clk) begin
        if (!clrn || clear) begin
            valid <= 1'b0;
            dout  <= INST_NOP;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer with imem request/grant/response handshake and IF/ID register.
// Optional statistics counters are enabled by defining FETCH_STAT_EN.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [31:0]       next_pc,
    input  logic              redirect,
    input  logic              stall,
    output logic [31:0]       pc,
    output logic [31:0]       pc4,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_inst,
`ifdef FETCH_STAT_EN
    output logic [31:0]       if_pc4,
    output logic [STAT_W-1:0] stat_fetch,
    output logic [STAT_W-1:0] stat_squash
`else
    output logic [31:0]       if_pc4
`endif
);

    fetch_state_t state, state_d;
    logic         drop, drop_d;
    logic         pc_en, kill, ifid_load, from_buf, buf_load, buf_clear, squash;
    logic         buf_valid;
    logic [31:0]  buf_data;
    logic [31:0]  pc_target;

    assign pc_target = {next_pc[31:2], 2'b00};
    assign pc4       = pc + PC_STEP;
    assign imem_req  = (state == ST_REQ) && clrn;
    assign imem_addr = pc;

    always_comb begin
        state_d   = state;
        drop_d    = drop;
        pc_en     = 1'b0;
        kill      = 1'b0;
        ifid_load = 1'b0;
        from_buf  = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        squash    = 1'b0;
        if (redirect) begin
            // Redirect wins over stall and response handling; in-flight work is squashed.
            pc_en = 1'b1;
            kill  = 1'b1;
            case (state)
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        squash  = 1'b1;
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    buf_clear = 1'b1;
                    squash    = 1'b1;
                    state_d   = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_gnt) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop_d  = 1'b0;
                            squash  = 1'b1;
                            state_d = ST_REQ;
                        end else if (!stall) begin
                            ifid_load = 1'b1;
                            pc_en     = 1'b1;
                            state_d   = ST_REQ;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        from_buf  = 1'b1;
                        buf_clear = 1'b1;
                        pc_en     = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= ST_REQ;
            drop  <= 1'b0;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            drop  <= drop_d;
            if (pc_en) pc <= pc_target;
        end
    end

    // pc has not moved since the response arrived, so pc4 is its link value.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            if_valid <= 1'b0;
            if_inst  <= INST_NOP;
            if_pc4   <= '0;
        end else if (kill) begin
            if_valid <= 1'b0;
        end else if (ifid_load) begin
            if_valid <= 1'b1;
            if_inst  <= (from_buf && buf_valid) ? buf_data : imem_rdata;
            if_pc4   <= pc4;
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk   (clk),
        .clrn  (clrn),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (imem_rdata),
        .valid (buf_valid),
        .dout  (buf_data)
    );

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk) begin
        if (!clrn) begin
            stat_fetch  <= '0;
            stat_squash <= '0;
        end else begin
            if (ifid_load && !kill) stat_fetch  <= stat_fetch + 1'b1;
            if (squash)             stat_squash <= stat_squash + 1'b1;
        end
    end
`else
    localparam int unsigned UNUSED_STAT_W = STAT_W;
`endif

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^next_pc[1:0];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
`ifdef FETCH_STAT_EN
    logic [31:0] stat_fetch;
    logic [31:0] stat_squash;
`endif

    logic        tie;
    logic [31:0] np_val;
    int          total = 0;
    int          bad   = 0;

    assign next_pc = tie ? pc4 : np_val;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0040),
        .STAT_W   (32)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .stall       (stall),
        .pc          (pc),
        .pc4         (pc4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
`ifdef FETCH_STAT_EN
        .if_pc4      (if_pc4),
        .stat_fetch  (stat_fetch),
        .stat_squash (stat_squash)
`else
        .if_pc4      (if_pc4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch of one word with stall low: grant edge then response edge.
    task automatic fetch(input logic [31:0] word);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; redirect = 1'b0; stall = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; tie = 1'b1; np_val = '0;

        // Reset
        tick(); tick();
        check("req_in_reset", imem_req, 1'b0);
        clrn = 1'b1;
        #1;
        check("rst_req", imem_req, 1'b1);
        check("rst_addr", imem_addr, 32'h40);
        check("rst_valid", if_valid, 1'b0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc4", if_pc4, 32'h0);
        check("rst_pc4c", pc4, 32'h44);

        // Sequential fetch
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("wait_req", imem_req, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
        tick();
        imem_rvalid = 1'b0;
        check("seq_valid", if_valid, 1'b1);
        check("seq_inst", if_inst, 32'h2001_0005);
        check("seq_ifpc4", if_pc4, 32'h44);
        check("seq_addr", imem_addr, 32'h44);
        check("seq_req", imem_req, 1'b1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("bubble", if_valid, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001;
        tick();
        imem_rvalid = 1'b0;
        check("seq2_inst", if_inst, 32'hDEAD_0001);
        check("seq2_ifpc4", if_pc4, 32'h48);
        check("seq2_pc", pc, 32'h48);

        // Stall for 3 cycles while a response arrives
        stall = 1'b1; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("stl1_inst", if_inst, 32'hDEAD_0001);
        check("stl1_valid", if_valid, 1'b1);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_rvalid = 1'b0;
        check("stl2_inst", if_inst, 32'hDEAD_0001);
        check("stl2_pc", pc, 32'h48);
        check("stl2_req", imem_req, 1'b0);
        tick();
        check("stl3_inst", if_inst, 32'hDEAD_0001);
        check("stl3_valid", if_valid, 1'b1);
        stall = 1'b0;
        tick();
        check("unstl_inst", if_inst, 32'h1111_2222);
        check("unstl_ifpc4", if_pc4, 32'h4C);
        check("unstl_pc", pc, 32'h4C);

        // Redirect in WAIT
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tie = 1'b0; np_val = 32'h0000_0100; redirect = 1'b1;
        tick();
        redirect = 1'b0; tie = 1'b1;
        check("rdw_pc", pc, 32'h100);
        check("rdw_valid", if_valid, 1'b0);
        check("rdw_req", imem_req, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        check("rdw_drop_valid", if_valid, 1'b0);
        check("rdw_drop_inst", if_inst, 32'h1111_2222);
        check("rdw_req2", imem_req, 1'b1);
        check("rdw_addr", imem_addr, 32'h100);
`ifdef FETCH_STAT_EN
        check("rdw_squash", stat_squash, 32'd1);
`endif

        // Redirect together with stall in HOLD
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444;
        tick();
        imem_rvalid = 1'b0;
        redirect = 1'b1; tie = 1'b0; np_val = 32'h0000_0203;
        tick();
        redirect = 1'b0; stall = 1'b0; tie = 1'b1;
        check("rdh_pc", pc, 32'h200);
        check("rdh_valid", if_valid, 1'b0);
        check("rdh_req", imem_req, 1'b1);
        fetch(32'h5555_6666);
        check("rdh_inst", if_inst, 32'h5555_6666);
        check("rdh_ifpc4", if_pc4, 32'h204);
`ifdef FETCH_STAT_EN
        check("rdh_squash", stat_squash, 32'd2);
        check("rdh_fetch", stat_fetch, 32'd4);
`endif

        // Wrap-around via redirect in REQ without grant
        redirect = 1'b1; tie = 1'b0; np_val = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; tie = 1'b1;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h7777_8888);
        check("wrap_inst", if_inst, 32'h7777_8888);
        check("wrap_ifpc4", if_pc4, 32'h0);
        check("wrap_pcnew", pc, 32'h0);

        // Redirect with grant in the same cycle: response later dropped
        imem_gnt = 1'b1; redirect = 1'b1; tie = 1'b0; np_val = 32'h0000_0300;
        tick();
        imem_gnt = 1'b0; redirect = 1'b0; tie = 1'b1;
        check("rdg_pc", pc, 32'h300);
        check("rdg_req", imem_req, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0000;
        tick();
        imem_rvalid = 1'b0;
        check("rdg_valid", if_valid, 1'b0);
        check("rdg_inst", if_inst, 32'h7777_8888);
        check("rdg_addr", imem_addr, 32'h300);
        fetch(32'h9999_AAAA);
        check("rdg_inst2", if_inst, 32'h9999_AAAA);
        check("rdg_ifpc4", if_pc4, 32'h304);
`ifdef FETCH_STAT_EN
        check("rdg_squash", stat_squash, 32'd3);
`endif

        // Reset mid-transaction; late response ignored
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        clrn = 1'b0;
        tick();
        check("mrst_req", imem_req, 1'b0);
        check("mrst_pc", pc, 32'h40);
        clrn = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_0000;
        tick();
        imem_rvalid = 1'b0;
        check("mrst_valid", if_valid, 1'b0);
        check("mrst_inst", if_inst, 32'h0);
        check("mrst_req2", imem_req, 1'b1);
        check("mrst_addr", imem_addr, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage sequencer that consumes the selected next PC and produces `pc4` for the next-PC select logic. It holds the architectural PC register and runs a request/grant/response handshake with instruction memory. It loads the IF/ID pipeline register and honours stall and redirect (taken branch or jump, `pcsrc != 0`) from the decode stage, squashing any wrong-path fetch still in flight.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `STAT_W`, default 32: width of the statistics counters (only used with `FETCH_STAT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `clrn`  in  1  reset, synchronous, active-low.
- `next_pc`  in  32  selected next PC from the next-PC select logic; bits [1:0] ignored.
- `redirect`  in  1  decode stage resolved a taken branch or jump (`pcsrc != 0`) this cycle.
- `stall`  in  1  hazard unit holds IF/ID.
- `pc`  out  32  current fetch PC (registered).
- `pc4`  out  32  `pc + 4`, combinational, modulo 2^32.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req` = 1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  instruction word returned this cycle.
- `imem_rdata`  in  32  returned instruction.
- `if_valid`  out  1  IF/ID holds a valid instruction.
- `if_inst`  out  32  IF/ID instruction.
- `if_pc4`  out  32  IF/ID `pc + 4` of that instruction.

## Operation

- States: REQ, WAIT, HOLD.
- **Reset** (`clrn` = 0 at edge): state REQ; `pc` = `RESET_PC`; `imem_req` = 0 during reset; `if_valid` = 0; `if_inst` = 0; `if_pc4` = 0; drop flag = 0; hold buffer cleared. Reset mid-transaction abandons it; a late `imem_rvalid` is ignored until a new grant.
- **REQ**: `imem_req` = 1. On `imem_gnt` go to WAIT. `imem_req` stays high and `imem_addr` stays stable until granted.
- **WAIT**: `imem_req` = 0. On `imem_rvalid`:
  - If drop = 1: discard the response, clear drop, go to REQ.
  - Else if `stall` = 0: load IF/ID (`if_valid` = 1, `if_inst` = `imem_rdata`, `if_pc4` = `pc` + 4), set `pc` <= `next_pc`, go to REQ.
  - Else: capture `imem_rdata` in the hold buffer, go to HOLD.
- **HOLD**: when `stall` falls, load IF/ID from the hold buffer, set `pc` <= `next_pc`, go to REQ.
- **No new instruction at an edge**: if `stall` = 0 and nothing is loaded, `if_valid` <= 0 (bubble). If `stall` = 1, IF/ID holds its value.
- **Redirect** (priority over `stall` and over response handling):
  - At that edge: `pc` <= {`next_pc`[31:2], 2'b00} and `if_valid` <= 0.
  - In REQ with no grant: reissue at the new PC.
  - In REQ with a grant at the same edge: set drop, go to WAIT.
  - In WAIT without `imem_rvalid`: set drop.
  - In WAIT with `imem_rvalid` at the same edge: discard the response, go to REQ.
  - In HOLD: discard the buffer, go to REQ.
- **Arithmetic**: all PC additions are modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.

## Timing

- Zero-wait memory (grant the cycle the request is seen, response the next cycle): one instruction enters IF/ID every 2 cycles.
- First `imem_req` = 1 in the first cycle after `clrn` rises.
- `pc4` is valid in the same cycle as `pc`.
- Redirect-to-request latency is 1 cycle, or 1 cycle after the in-flight response if a fetch is outstanding.
- Only one request outstanding at a time.

## Configuration

- `FETCH_STAT_EN` defined: adds outputs `stat_fetch` (count of instructions loaded into IF/ID) and `stat_squash` (count of responses discarded by drop or redirect). Each is `STAT_W` bits, reset to 0, and wraps on overflow.
- `FETCH_STAT_EN` not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure

- Shared package holds the state enum (REQ, WAIT, HOLD), `INST_NOP` (32'h0), and `PC_STEP` (32'd4).
- One sub-module, `fetch_hold_buf`: a one-entry instruction buffer with load, clear and valid.

## Test plan

- **Reset:** reset with `RESET_PC` = 32'h0000_0040, then release → `imem_addr` = 32'h40 with `imem_req` = 1 next cycle, and all IF/ID outputs 0.
- **Sequential fetch:** zero-wait memory returning 32'h2001_0005, `next_pc` tied to `pc4` → `if_inst` = 32'h2001_0005 and `if_pc4` = 32'h44; next request at 32'h44.
- **Stall:** stall for 3 cycles while a response arrives → IF/ID unchanged for 3 cycles; the buffered word loads on the cycle `stall` falls.
- **Redirect in WAIT:** assert `redirect` with `next_pc` = 32'h0000_0100 → `if_valid` = 0, the late response is discarded, the next request is at 32'h100, and `stat_squash` increments.
- **Simultaneous redirect and stall:** assert `redirect` and `stall` in HOLD → buffer discarded and `pc` = `next_pc`.
- **Wrap-around:** `pc` = 32'hFFFF_FFFC → `pc4` = 32'h0000_0000 and `if_pc4` = 0.
